// File: rtl/mult_exec_unit.sv
// Pipelined signed 32x32 multiply execution unit: consumes issue-queue entries,
// carries {tag, product} through LATENCY stages and requests the CDB at the last one.

module mult_exec_stage #(
  parameter int W = 69
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)     q <= '0;
    else if (en) q <= d;
  end

endmodule

module mult_exec_unit #(
  parameter int LATENCY   = 4,
  parameter bit RESULT_HI = 1'b0
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        IssueQue_Ready,
  input  logic [31:0] IssueQue_Rs_Data,
  input  logic [31:0] IssueQue_Rt_Data,
  input  logic [4:0]  IssueQue_Rd_Tag,
  output logic        Mult_Issue,
  output logic        Mult_Req,
  output logic [4:0]  Mult_Tag,
  output logic [31:0] Mult_Data,
  input  logic        CDB_Grant,
  input  logic        RB_Flush_Valid,
  output logic        Mult_Busy
);

  typedef struct packed {
    logic [4:0]  tag;
    logic [63:0] prod;
  } stage_t;

  localparam int SW = $bits(stage_t);

  logic [LATENCY:1] vld_pipe;
  logic             stall;
  logic [31:0]      op_a, op_b;
  logic [4:0]       op_tag;
  logic [63:0]      prod;
  stage_t           st_q [LATENCY:2];

  // Global stall: the whole pipe freezes while the finished result waits for grant.
  assign stall = vld_pipe[LATENCY] & ~CDB_Grant;

  // Reset gating keeps the queue from dropping an entry we would discard anyway.
  assign Mult_Issue = IssueQue_Ready & ~stall & ~RB_Flush_Valid & ~Rst;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)                 vld_pipe <= '0;
    else if (RB_Flush_Valid) vld_pipe <= '0;
    else if (!stall)         vld_pipe <= {vld_pipe[LATENCY-1:1], Mult_Issue};
  end

  // S1: operand capture
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      op_a   <= '0;
      op_b   <= '0;
      op_tag <= '0;
    end else if (!stall) begin
      op_a   <= IssueQue_Rs_Data;
      op_b   <= IssueQue_Rt_Data;
      op_tag <= IssueQue_Rd_Tag;
    end
  end

  // Low 64 bits of the sign-extended product equal the signed 64-bit product.
  assign prod = {{32{op_a[31]}}, op_a} * {{32{op_b[31]}}, op_b};

  generate
    for (genvar s = 2; s <= LATENCY; s++) begin : g_stage
      stage_t d;
      if (s == 2) begin : g_mul
        assign d = {op_tag, prod};
      end else begin : g_pass
        assign d = st_q[s-1];
      end
      mult_exec_stage #(.W(SW)) u_stage (
        .Clk (Clk),
        .Rst (Rst),
        .en  (~stall),
        .d   (d),
        .q   (st_q[s])
      );
    end
  endgenerate

  assign Mult_Req  = vld_pipe[LATENCY];
  assign Mult_Tag  = st_q[LATENCY].tag;
  assign Mult_Data = RESULT_HI ? st_q[LATENCY].prod[63:32] : st_q[LATENCY].prod[31:0];
  assign Mult_Busy = |vld_pipe;

endmodule
